// File: rtl/frame_pattern_source_if.sv
// Avalon-ST video stream: pixel data with valid/ready handshake and packet framing.
interface frame_pattern_source_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );
endinterface

// File: rtl/frame_pattern_source.sv
// Avalon-ST frame source: WIDTH x HEIGHT frames from a ROM image or a generated test pattern.
// Stages: S0 pixel counters -> S1 ROM read / pattern registers -> S2 output register.
module frame_pattern_source #(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned CH_BITS      = 4,
  parameter              ROM_FILE     = "chad-ho-320x240.mif",
  parameter int unsigned GRAD_SHIFT   = 5,
  parameter int unsigned CHECK_SHIFT  = 4,
  parameter int unsigned FCOUNT_W     = 16,
  localparam int unsigned DATA_WIDTH  = NUM_CHANNELS * CH_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [DATA_WIDTH-1:0]      solid_colour,
  frame_pattern_source_if.master     src,
  output logic [FCOUNT_W-1:0]        frame_count,
  output logic                       busy
);

  localparam int unsigned PIXELS = WIDTH * HEIGHT;
  localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned AW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [AW-1:0]         addr;
  logic [1:0]            mode_lat;
  logic [DATA_WIDTH-1:0] colour_lat;

  logic                  s1_valid, s1_sop, s1_eop, s1_rom_sel;
  logic [DATA_WIDTH-1:0] s1_pat, rom_word;

  logic                  advance, issue, last_x, last_pix;
  logic [CH_BITS-1:0]    level;
  logic                  chk_bit;
  logic [DATA_WIDTH-1:0] pattern;

  assign advance  = !src.valid || src.ready;
  assign issue    = advance && (state == StRun);
  assign last_x   = (x == XW'(WIDTH - 1));
  assign last_pix = last_x && (y == YW'(HEIGHT - 1));
  assign busy     = (state == StRun) || s1_valid || src.valid;

  always_comb begin
    level   = CH_BITS'(32'(x) >> GRAD_SHIFT);
    chk_bit = 1'(32'(x) >> CHECK_SHIFT) ^ 1'(32'(y) >> CHECK_SHIFT);
    pattern = '0;
    unique case (mode_lat)
      2'd1:    pattern = colour_lat;
      2'd2:    pattern = {NUM_CHANNELS{level}};
      2'd3:    pattern = chk_bit ? '1 : '0;
      default: pattern = '0;
    endcase
  end

  // Frame sequencer: mode and colour only change when the last pixel of a frame is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      mode_lat   <= '0;
      colour_lat <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (enable) begin
            mode_lat   <= mode;
            colour_lat <= solid_colour;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            state      <= StRun;
          end
        end
        StRun: begin
          if (advance) begin
            if (last_pix) begin
              x    <= '0;
              y    <= '0;
              addr <= '0;
              if (enable) begin
                mode_lat   <= mode;
                colour_lat <= solid_colour;
              end else begin
                state <= StIdle;
              end
            end else begin
              addr <= addr + 1'b1;
              if (last_x) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Block ROM with its read register; holding the read enable low keeps the word during a stall.
  (* ram_init_file = ROM_FILE *) logic [DATA_WIDTH-1:0] rom [PIXELS];

  always_ff @(posedge clk) begin
    if (advance) begin
      rom_word <= rom[addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid          <= 1'b0;
      s1_sop            <= 1'b0;
      s1_eop            <= 1'b0;
      s1_rom_sel        <= 1'b0;
      s1_pat            <= '0;
      src.valid         <= 1'b0;
      src.data          <= '0;
      src.startofpacket <= 1'b0;
      src.endofpacket   <= 1'b0;
      frame_count       <= '0;
    end else begin
      if (advance) begin
        s1_valid          <= issue;
        s1_sop            <= issue && (x == '0) && (y == '0);
        s1_eop            <= issue && last_pix;
        s1_rom_sel        <= (mode_lat == 2'd0);
        s1_pat            <= pattern;
        src.valid         <= s1_valid;
        src.data          <= s1_rom_sel ? rom_word : s1_pat;
        src.startofpacket <= s1_sop;
        src.endofpacket   <= s1_eop;
      end
      if (src.valid && src.ready && src.endofpacket) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pattern_source.sv
// Randomised bench for frame_pattern_source: every beat is compared against a per-pixel
// model computed from frame index, latched mode and (x, y).
module tb_frame_pattern_source;

  localparam int unsigned W   = 48;
  localparam int unsigned H   = 34;
  localparam int unsigned NC  = 3;
  localparam int unsigned CB  = 4;
  localparam int unsigned GS  = 5;
  localparam int unsigned CS  = 4;
  localparam int unsigned FW  = 16;
  localparam int unsigned DW  = NC * CB;
  localparam int unsigned PIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] solid_colour = '0;
  logic [FW-1:0] frame_count;
  logic          busy;

  frame_pattern_source_if #(.DATA_WIDTH(DW)) st ();

  frame_pattern_source #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .NUM_CHANNELS(NC),
    .CH_BITS     (CB),
    .ROM_FILE    ("tb_image.mif"),
    .GRAD_SHIFT  (GS),
    .CHECK_SHIFT (CS),
    .FCOUNT_W    (FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .solid_colour(solid_colour),
    .src         (st),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] rom_img [PIX];

  function automatic logic [DW-1:0] model_pixel(input int m, input logic [DW-1:0] col,
                                                input int unsigned k);
    int unsigned   px, py;
    logic [CB-1:0] lvl;
    logic [DW-1:0] v;
    px  = k % W;
    py  = k / W;
    lvl = CB'(px >> GS);
    case (m)
      0:       v = rom_img[k];
      1:       v = col;
      2:       v = {NC{lvl}};
      default: v = ((((px >> CS) ^ (py >> CS)) & 1) != 0) ? '1 : '0;
    endcase
    return v;
  endfunction

  // Ready generator: random 50% pattern or a fixed level.
  bit rand_ready  = 1'b0;
  bit ready_level = 1'b1;
  initial st.ready = 1'b0;
  always @(posedge clk) begin
    #1;
    st.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Scoreboard: beat index within the frame, frame settings captured at the frame's first beat.
  int unsigned   beat        = 0;
  int unsigned   frames_done = 0;
  int unsigned   exp_fc      = 0;
  bit            captured    = 1'b0;
  bit            prev_stall  = 1'b0;
  int            fmode       = 0;
  logic [DW-1:0] fcol        = '0;

  always @(negedge clk) begin
    if (!reset) begin
      beat       = 0;
      exp_fc     = 0;
      captured   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_count", 32'(frame_count), exp_fc);
      if (prev_stall) check("stall_valid", 32'(st.valid), 32'd1);
      if (st.valid) begin
        if (!captured) begin
          fmode    = int'(mode);
          fcol     = solid_colour;
          captured = 1'b1;
        end
        check("data", 32'(st.data), 32'(model_pixel(fmode, fcol, beat)));
        check("sop", 32'(st.startofpacket), 32'(beat == 0));
        check("eop", 32'(st.endofpacket), 32'(beat == PIX - 1));
        if (st.ready) begin
          if (beat == PIX - 1) begin
            beat     = 0;
            captured = 1'b0;
            frames_done++;
            exp_fc   = (exp_fc + 1) % (1 << FW);
          end else begin
            beat++;
          end
        end
      end
      prev_stall = st.valid && !st.ready;
    end
  end

  task automatic wait_frames(input int unsigned n);
    int unsigned target;
    int unsigned budget;
    target = frames_done + n;
    budget = 0;
    while (frames_done < target && budget < 5 * PIX * n + 200) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("frames_reached", frames_done, target);
  endtask

  task automatic wait_beat(input int unsigned k);
    int unsigned budget;
    budget = 0;
    while (beat < k && budget < 4 * PIX) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("beat_reached", 32'(beat >= k), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(st.valid), 32'd0);
    check({tag, "_sop"}, 32'(st.startofpacket), 32'd0);
    check({tag, "_eop"}, 32'(st.endofpacket), 32'd0);
    check({tag, "_data"}, 32'(st.data), 32'd0);
    check({tag, "_fcount"}, 32'(frame_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_startup(input string tag);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_latency"}, 32'(st.valid), 32'(i == 3));
    end
    check({tag, "_sop"}, 32'(st.startofpacket), 32'd1);
    check({tag, "_fcount"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < PIX; i++) begin
      rom_img[i] = DW'($urandom);
      dut.rom[i] = rom_img[i];
    end
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");

    // Gradient from reset release, full throughput.
    enable      = 1'b1;
    mode        = 2'd2;
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_startup("start");
    check("first_data", 32'(st.data), 32'd0);
    wait_frames(1);
    check("fc_after_frame", 32'(frame_count), 32'd1);
    check("no_gap_valid", 32'(st.valid), 32'd1);
    check("no_gap_sop", 32'(st.startofpacket), 32'd1);

    // ROM image under random back-pressure.
    wait_beat(8);
    mode       = 2'd0;
    rand_ready = 1'b1;
    wait_frames(3);

    // Checkerboard.
    wait_beat(8);
    mode = 2'd3;
    wait_frames(2);

    // Solid colour changed mid-frame takes effect on the next frame only.
    wait_beat(8);
    mode         = 2'd1;
    solid_colour = 12'hA5C;
    wait_frames(1);
    wait_beat(PIX / 2);
    solid_colour = 12'h123;
    wait_frames(2);

    // Drop enable mid-frame: frame completes, pipeline drains, then restart.
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    wait_beat(100);
    enable = 1'b0;
    wait_frames(1);
    check("drain_valid", 32'(st.valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    repeat (4) begin
      @(posedge clk);
      #2;
      check("idle_valid", 32'(st.valid), 32'd0);
    end
    enable = 1'b1;
    wait_frames(1);

    // Reset in the middle of a frame.
    wait_beat(1000);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_startup("restart");
    wait_frames(1);
    check("fc_after_restart", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
